// File: rtl/bpm_estimator_if.sv
// Beat-rate link between the audio beat detector and the BPM estimator.
// The master side drives the time base and beat pulses; the slave side returns the estimate.
interface bpm_estimator_if #(
    parameter int BPM_W = 8
);
    logic             tick;
    logic             beat_in;
    logic [BPM_W-1:0] BPM_estimate;
    logic             bpm_valid;
    logic             locked;

    modport master (
        output tick,
        output beat_in,
        input  BPM_estimate,
        input  bpm_valid,
        input  locked
    );

    modport slave (
        input  tick,
        input  beat_in,
        output BPM_estimate,
        output bpm_valid,
        output locked
    );
endinterface

// File: rtl/bpm_estimator.sv
// Measures tick intervals between beats, averages the last AVG_DEPTH of them and converts
// the average to beats per minute with a bit-serial restoring divider.
module bpm_estimator #(
    parameter int TICK_HZ   = 1000,
    parameter int MAX_BPM   = 200,
    parameter int MIN_BPM   = 30,
    parameter int AVG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    bpm_estimator_if.slave   bus
);
    localparam int NUMER        = 60 * TICK_HZ;
    localparam int MIN_INTERVAL = NUMER / MAX_BPM;
    localparam int TIMEOUT      = NUMER / MIN_BPM;
    localparam int CNT_W        = $clog2(TIMEOUT + 1);
    localparam int NUM_W        = $clog2(NUMER + 1);
    localparam int BPM_W        = $clog2(MAX_BPM + 1);
    localparam int LOG2_D       = $clog2(AVG_DEPTH);
    localparam int SUM_W        = CNT_W + LOG2_D;
    localparam int FILL_W       = $clog2(AVG_DEPTH + 1);
    localparam int DIV_CNT_W    = $clog2(NUM_W);

    localparam logic [CNT_W-1:0]     MIN_INT_V = CNT_W'(MIN_INTERVAL);
    localparam logic [CNT_W-1:0]     TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [NUM_W-1:0]     NUMER_V   = NUM_W'(NUMER);
    localparam logic [NUM_W-1:0]     MAX_Q_V   = NUM_W'(MAX_BPM);
    localparam logic [BPM_W-1:0]     MAX_BPM_V = BPM_W'(MAX_BPM);
    localparam logic [FILL_W-1:0]    DEPTH_V   = FILL_W'(AVG_DEPTH);
    localparam logic [DIV_CNT_W-1:0] DIV_LAST  = DIV_CNT_W'(NUM_W - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, UPDATE} state_t;

    // Clamp before truncation so large quotients saturate instead of wrapping.
    function automatic logic [BPM_W-1:0] clamp_bpm(input logic [NUM_W-1:0] q);
        if (q > MAX_Q_V)
            return MAX_BPM_V;
        return q[BPM_W-1:0];
    endfunction

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [FILL_W-1:0]    fill;
    logic [SUM_W-1:0]     sum;
    logic [CNT_W-1:0]     hist [AVG_DEPTH];
    logic [NUM_W-1:0]     rem;
    logic [NUM_W-1:0]     quo;
    logic [DIV_CNT_W-1:0] div_cnt;
    logic [BPM_W-1:0]     bpm_q;
    logic                 valid_q;
    logic                 locked_q;

    logic [CNT_W-1:0]     avg;
    logic [NUM_W:0]       trial;
    logic [NUM_W:0]       avg_ext;
    logic                 take;
    logic                 cnt_inc;
    logic                 accept;
    logic [SUM_W-1:0]     sum_prefill;
    logic [SUM_W-1:0]     sum_shift;

    assign avg         = sum[SUM_W-1:LOG2_D];
    assign avg_ext     = (NUM_W + 1)'(avg);
    // Dividend bits are consumed from the top of quo while quotient bits enter at the bottom.
    assign trial       = {rem, quo[NUM_W-1]};
    assign take        = (trial >= avg_ext);
    assign cnt_inc     = bus.tick && (cnt != TIMEOUT_V);
    assign accept      = bus.beat_in && (cnt >= MIN_INT_V);
    assign sum_prefill = SUM_W'(cnt) << LOG2_D;
    assign sum_shift   = sum - SUM_W'(hist[AVG_DEPTH-1]) + SUM_W'(cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            fill     <= '0;
            sum      <= '0;
            for (int i = 0; i < AVG_DEPTH; i++)
                hist[i] <= '0;
            rem      <= '0;
            quo      <= '0;
            div_cnt  <= '0;
            bpm_q    <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.beat_in) begin
                        fill  <= '0;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (accept) begin
                        // First interval after re-arming fills every slot so the average is valid at once.
                        if (fill == '0) begin
                            for (int i = 0; i < AVG_DEPTH; i++)
                                hist[i] <= cnt;
                            sum <= sum_prefill;
                        end else begin
                            hist[0] <= cnt;
                            for (int i = 1; i < AVG_DEPTH; i++)
                                hist[i] <= hist[i-1];
                            sum <= sum_shift;
                        end
                        if (fill != DEPTH_V)
                            fill <= fill + 1'b1;
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= NUMER_V;
                        div_cnt <= '0;
                        state   <= DIVIDE;
                    end else if (cnt == TIMEOUT_V) begin
                        bpm_q    <= '0;
                        valid_q  <= 1'b1;
                        locked_q <= 1'b0;
                        fill     <= '0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else if (cnt_inc) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIVIDE: begin
                    if (cnt_inc)
                        cnt <= cnt + 1'b1;
                    rem     <= take ? NUM_W'(trial - avg_ext) : trial[NUM_W-1:0];
                    quo     <= {quo[NUM_W-2:0], take};
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == DIV_LAST)
                        state <= UPDATE;
                end
                UPDATE: begin
                    if (cnt_inc)
                        cnt <= cnt + 1'b1;
                    bpm_q    <= clamp_bpm(quo);
                    valid_q  <= 1'b1;
                    locked_q <= (fill == DEPTH_V);
                    state    <= MEASURE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BPM_estimate = bpm_q;
    assign bus.bpm_valid    = valid_q;
    assign bus.locked       = locked_q;
endmodule

// File: tb/tb_bpm_estimator.sv
// Directed bench for bpm_estimator: an interval/average reference model checked every cycle,
// plus literal expectations for the estimates produced by each stimulus phase.
module tb_bpm_estimator;
    localparam int TICK_HZ   = 1000;
    localparam int MAX_BPM   = 200;
    localparam int MIN_BPM   = 30;
    localparam int AVG_DEPTH = 4;
    localparam int NUMER     = 60 * TICK_HZ;
    localparam int MIN_INT   = NUMER / MAX_BPM;
    localparam int TIMEOUT   = NUMER / MIN_BPM;
    localparam int NUM_W     = $clog2(NUMER + 1);
    localparam int BPM_W     = $clog2(MAX_BPM + 1);
    // Edges from the beat-sampling edge to the edge that writes the estimate.
    localparam int OUT_EDGE  = NUM_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bpm_estimator_if #(.BPM_W(BPM_W)) bus ();

    bpm_estimator #(
        .TICK_HZ  (TICK_HZ),
        .MAX_BPM  (MAX_BPM),
        .MIN_BPM  (MIN_BPM),
        .AVG_DEPTH(AVG_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks ticks since the last accepted beat, a list of recent intervals,
    // and the cycle count until the pending estimate appears.
    int m_armed  = 0;
    int m_cnt    = 0;
    int m_busy   = 0;
    int m_fill   = 0;
    int m_pend   = 0;
    int m_bpm    = 0;
    int m_valid  = 0;
    int m_locked = 0;
    int m_hist[$];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_armed = 0; m_cnt = 0; m_busy = 0; m_fill = 0;
                m_bpm = 0; m_valid = 0; m_locked = 0;
                m_hist.delete();
            end else begin
                int t, b, s;
                t = int'(bus.tick);
                b = int'(bus.beat_in);
                m_valid = 0;
                if (m_armed == 0) begin
                    m_cnt = 0;
                    if (b != 0) begin
                        m_armed = 1;
                        m_fill  = 0;
                    end
                end else if (m_busy > 0) begin
                    if (t != 0 && m_cnt < TIMEOUT) m_cnt++;
                    m_busy--;
                    if (m_busy == 0) begin
                        m_bpm    = m_pend;
                        m_valid  = 1;
                        m_locked = (m_fill == AVG_DEPTH) ? 1 : 0;
                    end
                end else if (b != 0 && m_cnt >= MIN_INT) begin
                    if (m_fill == 0) begin
                        m_hist.delete();
                        repeat (AVG_DEPTH) m_hist.push_back(m_cnt);
                    end else begin
                        m_hist.push_front(m_cnt);
                        void'(m_hist.pop_back());
                    end
                    if (m_fill < AVG_DEPTH) m_fill++;
                    s = 0;
                    foreach (m_hist[i]) s += m_hist[i];
                    m_pend = NUMER / (s / AVG_DEPTH);
                    if (m_pend > MAX_BPM) m_pend = MAX_BPM;
                    m_cnt  = 0;
                    m_busy = OUT_EDGE;
                end else if (m_cnt == TIMEOUT) begin
                    m_bpm = 0; m_valid = 1; m_locked = 0;
                    m_armed = 0; m_fill = 0; m_cnt = 0;
                end else if (t != 0 && m_cnt < TIMEOUT) begin
                    m_cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_bpm",    32'(bus.BPM_estimate), m_bpm);
            chk("model_valid",  32'(bus.bpm_valid),    m_valid);
            chk("model_locked", 32'(bus.locked),       m_locked);
        end
    end

    task automatic step(input logic t, input logic b);
        bus.tick    = t;
        bus.beat_in = b;
        @(posedge clk);
        #1;
    endtask

    // One beat cycle, then n cycles with tick high (so the next beat sees an interval of n).
    // An optional extra beat is injected at gap index drop_at.
    task automatic beat_then(input int n, input int drop_at,
                             output int pulses, output int first_off, output int last_val);
        pulses    = 0;
        first_off = -1;
        last_val  = -1;
        step(1'b1, 1'b1);
        for (int k = 1; k <= n; k++) begin
            step(1'b1, k == drop_at);
            if (bus.bpm_valid) begin
                if (pulses == 0) first_off = k;
                pulses++;
                last_val = int'(bus.BPM_estimate);
            end
        end
    endtask

    int p, off, val;
    int exp_avg [4] = '{109, 120, 133, 150};

    initial begin
        bus.tick    = 1'b0;
        bus.beat_in = 1'b0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bpm",    32'(bus.BPM_estimate), 0);
        chk("reset_valid",  32'(bus.bpm_valid),    0);
        chk("reset_locked", 32'(bus.locked),       0);
        rst = 1'b0;
        repeat (5) step(1'b1, 1'b0);

        // Steady 100 BPM: first beat arms, then one estimate per beat
        beat_then(600, 0, p, off, val);
        chk("arm_no_pulse", 32'(p), 0);
        for (int i = 1; i <= 5; i++) begin
            beat_then(600, 0, p, off, val);
            chk("steady_pulses", 32'(p), 1);
            chk("steady_latency", 32'(off), OUT_EDGE);
            chk("steady_bpm", 32'(val), 100);
            chk("steady_locked", 32'(bus.locked), (i >= 4) ? 1 : 0);
        end

        // Beat injected during DIVIDE is dropped; then averaging 400-tick intervals
        beat_then(400, 5, p, off, val);
        chk("drop_pulses", 32'(p), 1);
        chk("drop_bpm", 32'(val), 100);
        for (int i = 0; i < 4; i++) begin
            beat_then((i == 3) ? 343 : 400, 0, p, off, val);
            chk("avg_pulses", 32'(p), 1);
            chk("avg_bpm", 32'(val), exp_avg[i]);
        end

        // Timeout after the 343 interval closes: estimate then forced zero
        beat_then(2010, 0, p, off, val);
        chk("timeout_pulses", 32'(p), 2);
        chk("timeout_bpm", 32'(val), 0);
        chk("timeout_locked", 32'(bus.locked), 0);
        beat_then(343, 0, p, off, val);
        chk("rearm_no_pulse", 32'(p), 0);
        beat_then(600, 0, p, off, val);
        chk("single343_bpm", 32'(val), 174);
        chk("single343_locked", 32'(bus.locked), 0);

        // Debounce and clamp: rejected beat at 150, accepted at 300 ticks
        beat_then(2100, 0, p, off, val);
        chk("timeout2_pulses", 32'(p), 2);
        beat_then(150, 0, p, off, val);
        chk("rearm2_no_pulse", 32'(p), 0);
        beat_then(149, 0, p, off, val);
        chk("debounce_no_pulse", 32'(p), 0);
        beat_then(600, 0, p, off, val);
        chk("clamp_pulses", 32'(p), 1);
        chk("clamp_bpm", 32'(val), 200);

        // Reset five cycles into a division
        step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("midreset_bpm",    32'(bus.BPM_estimate), 0);
        chk("midreset_valid",  32'(bus.bpm_valid),    0);
        chk("midreset_locked", 32'(bus.locked),       0);
        repeat (3) step(1'b1, 1'b0);
        rst = 1'b0;
        beat_then(600, 0, p, off, val);
        chk("post_reset_arm", 32'(p), 0);
        beat_then(40, 0, p, off, val);
        chk("post_reset_pulses", 32'(p), 1);
        chk("post_reset_bpm", 32'(val), 100);

        repeat (5) step(1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
